// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Op codes, FSM encoding and the captured request bundle.
package alu_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHIFT_W = 4;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_AND  = 3'b010;
  localparam op_t OP_XOR  = 3'b011;
  localparam op_t OP_NOR  = 3'b100;
  localparam op_t OP_SHL  = 3'b101;
  localparam op_t OP_ROTL = 3'b110;
  localparam op_t OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    op_t                 op;
    logic [DATA_W-1:0]   srca;
    logic [DATA_W-1:0]   srcb;
    logic [SHIFT_W-1:0]  shift;
    logic                owner;
  } req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters.
// Zero flag is meaningful only for the subtract/compare op.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  srca,
  input  logic [DATA_W-1:0]  srcb,
  input  op_t                alucontrol,
  input  logic [SHIFT_W-1:0] shift,
  output logic [DATA_W-1:0]  aluresult,
  output logic               zero
);

  logic [2*DATA_W-1:0] dbl;

  always_comb begin
    aluresult = '0;
    dbl       = {srca, srca} << shift;
    unique case (alucontrol)
      OP_ADD:  aluresult = srca + srcb;
      OP_OR:   aluresult = srca | srcb;
      OP_AND:  aluresult = srca & srcb;
      OP_XOR:  aluresult = srca ^ srcb;
      OP_NOR:  aluresult = ~(srca | srcb);
      OP_SHL:  aluresult = srca << shift;
      OP_ROTL: aluresult = dbl[2*DATA_W-1:DATA_W];
      OP_SUB:  aluresult = srca - srcb;
      default: aluresult = '0;
    endcase
  end

  assign zero = (alucontrol == OP_SUB) &&
                (srca == srcb);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port front end sharing one ALU: arbitrate, capture,
// execute for one cycle, then hold the response until taken.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [DATA_W-1:0]  req0_srca,
  input  logic [DATA_W-1:0]  req1_srca,
  input  logic [DATA_W-1:0]  req0_srcb,
  input  logic [DATA_W-1:0]  req1_srcb,
  input  op_t                req0_op,
  input  op_t                req1_op,
  input  logic [SHIFT_W-1:0] req0_shift,
  input  logic [SHIFT_W-1:0] req1_shift,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_zero,
  output logic               busy
);

  state_t            state, state_nxt;
  req_t              cur, pick;
  logic              last_owner;
  logic              winner;
  logic              accept;
  logic [DATA_W-1:0] alu_y;
  logic              alu_z;

  // Tie goes to port 0, or away from the last owner.
  always_comb begin
    winner = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b10): winner = 1'b1;
      (req_valid == 2'b11):
        winner = FIXED_PRIO ? 1'b0 : ~last_owner;
      default: winner = 1'b0;
    endcase
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    pick = winner ?
      '{op: req1_op, srca: req1_srca,
        srcb: req1_srcb, shift: req1_shift,
        owner: 1'b1} :
      '{op: req0_op, srca: req0_srca,
        srcb: req0_srcb, shift: req0_shift,
        owner: 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP:
        if (rsp_ready[cur.owner]) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:
        if (|req_valid) req_ready[winner] = 1'b1;
      ST_RESP: rsp_valid[cur.owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      last_owner <= 1'b1;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (state == ST_IDLE && accept) begin
        cur        <= pick;
        last_owner <= winner;
      end
      if (state == ST_EXEC) begin
        rsp_result <= alu_y;
        rsp_zero   <= alu_z;
      end
    end
  end

  alu_arbiter_alu u_alu (
    .srca       (cur.srca),
    .srcb       (cur.srcb),
    .alucontrol (cur.op),
    .shift      (cur.shift),
    .aluresult  (alu_y),
    .zero       (alu_z)
  );

endmodule
